// File: rtl/one_hot_decoder.sv
// rtl/one_hot_decoder.sv - registered N-to-2^N one-hot decoder with pulse hold and one-deep pending slot
// Optional sticky drop flag on port ovf when DEC_OVF_EN is defined.
module one_hot_decoder #(
    parameter int N_SEL       = 3,
    parameter int OUT_W       = 1 << N_SEL,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vin,
    input  logic [N_SEL-1:0] a,
    output logic             rdy,
    output logic [OUT_W-1:0] out,
    output logic             vout,
`ifdef DEC_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_HOLD  = 1'b1;
    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    logic             r_state;
    logic [OUT_W-1:0] r_out;
    logic             r_vout;
    logic [7:0]       r_cnt;
    logic [N_SEL-1:0] r_pend;
    logic             r_pend_v;

    logic [OUT_W-1:0] w_dec_a;
    logic [OUT_W-1:0] w_dec_pend;
    logic             w_final;

    assign w_dec_a    = {{(OUT_W-1){1'b0}}, 1'b1} << a;
    assign w_dec_pend = {{(OUT_W-1){1'b0}}, 1'b1} << r_pend;
    assign w_final    = (r_cnt == 8'd0);

    // rdy comes only from registered state so the sender never sees a loop through vin
    assign rdy  = ~r_pend_v;
    assign busy = (r_state == S_HOLD) | r_pend_v;
    assign out  = r_out;
    assign vout = r_vout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_vout   <= 1'b0;
            r_cnt    <= 8'd0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (vin) begin
                        r_out   <= w_dec_a;
                        r_vout  <= 1'b1;
                        r_cnt   <= HOLD_M1;
                        r_state <= S_HOLD;
                    end else begin
                        r_out   <= '0;
                        r_vout  <= 1'b0;
                    end
                end
                default: begin
                    if (!w_final) begin
                        r_cnt <= r_cnt - 8'd1;
                        if (vin && !r_pend_v) begin
                            r_pend   <= a;
                            r_pend_v <= 1'b1;
                        end
                    end else if (r_pend_v) begin
                        // a code arriving here with pend_v set sees rdy=0 and is dropped
                        r_out    <= w_dec_pend;
                        r_cnt    <= HOLD_M1;
                        r_pend_v <= 1'b0;
                    end else if (vin) begin
                        r_out <= w_dec_a;
                        r_cnt <= HOLD_M1;
                    end else begin
                        r_out   <= '0;
                        r_vout  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef DEC_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (vin && !rdy) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_one_hot_decoder.sv
// tb/tb_one_hot_decoder.sv - directed self-checking bench for one_hot_decoder (HOLD_CYCLES 4, 1 and 3)
module tb_one_hot_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_vin = 1'b0, b_vin = 1'b0, c_vin = 1'b0;
    logic [2:0] a_a = '0, b_a = '0, c_a = '0;
    logic       a_rdy, b_rdy, c_rdy;
    logic [7:0] a_out, b_out, c_out;
    logic       a_vout, b_vout, c_vout;
    logic       a_busy, b_busy, c_busy;
`ifdef DEC_OVF_EN
    logic       a_ovf, b_ovf, c_ovf;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    one_hot_decoder #(.N_SEL(3), .HOLD_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .vin(a_vin), .a(a_a), .rdy(a_rdy),
        .out(a_out), .vout(a_vout),
`ifdef DEC_OVF_EN
        .ovf(a_ovf),
`endif
        .busy(a_busy));

    one_hot_decoder #(.N_SEL(3), .HOLD_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .vin(b_vin), .a(b_a), .rdy(b_rdy),
        .out(b_out), .vout(b_vout),
`ifdef DEC_OVF_EN
        .ovf(b_ovf),
`endif
        .busy(b_busy));

    one_hot_decoder #(.N_SEL(3), .HOLD_CYCLES(3)) u_c (
        .clk(clk), .rst_n(rst_n), .vin(c_vin), .a(c_a), .rdy(c_rdy),
        .out(c_out), .vout(c_vout),
`ifdef DEC_OVF_EN
        .ovf(c_ovf),
`endif
        .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] o, input logic v, input logic r);
        chk({tag, "_out"}, 32'(a_out), 32'(o));
        chk({tag, "_vout"}, 32'(a_vout), 32'(v));
        chk({tag, "_rdy"}, 32'(a_rdy), 32'(r));
    endtask

    initial begin
        #12;
        chk("rst_out", 32'(a_out), 32'h00);
        chk("rst_vout", 32'(a_vout), 32'h0);
        chk("rst_rdy", 32'(a_rdy), 32'h1);
        chk("rst_busy", 32'(a_busy), 32'h0);
`ifdef DEC_OVF_EN
        chk("rst_ovf", 32'(a_ovf), 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // single code, HOLD 4
        a_vin = 1'b1; a_a = 3'd6;
        tick(); a_vin = 1'b0;
        chk_a("single_c1", 8'h40, 1'b1, 1'b1);
        chk("single_busy", 32'(a_busy), 32'h1);
        tick(); chk_a("single_c2", 8'h40, 1'b1, 1'b1);
        tick(); chk_a("single_c3", 8'h40, 1'b1, 1'b1);
        tick(); chk_a("single_c4", 8'h40, 1'b1, 1'b1);
        tick(); chk_a("single_end", 8'h00, 1'b0, 1'b1);
        chk("single_end_busy", 32'(a_busy), 32'h0);

        // pending: a=2 then a=7 two cycles later
        a_vin = 1'b1; a_a = 3'd2;
        tick(); a_vin = 1'b0;
        chk_a("pend_c1", 8'h04, 1'b1, 1'b1);
        tick(); chk_a("pend_c2", 8'h04, 1'b1, 1'b1);
        a_vin = 1'b1; a_a = 3'd7;
        tick(); a_vin = 1'b0;
        chk_a("pend_c3", 8'h04, 1'b1, 1'b0);
        tick(); chk_a("pend_c4", 8'h04, 1'b1, 1'b0);
        tick(); chk_a("pend_c5", 8'h80, 1'b1, 1'b1);
        tick(); chk_a("pend_c6", 8'h80, 1'b1, 1'b1);
        tick(); chk_a("pend_c7", 8'h80, 1'b1, 1'b1);
        tick(); chk_a("pend_c8", 8'h80, 1'b1, 1'b1);
        tick(); chk_a("pend_end", 8'h00, 1'b0, 1'b1);

        // drop: 1, 3, 4 on consecutive cycles
        a_vin = 1'b1; a_a = 3'd1;
        tick(); chk_a("drop_c1", 8'h02, 1'b1, 1'b1);
        a_a = 3'd3;
        tick(); chk_a("drop_c2", 8'h02, 1'b1, 1'b0);
        a_a = 3'd4;
        tick(); a_vin = 1'b0;
        chk_a("drop_c3", 8'h02, 1'b1, 1'b0);
`ifdef DEC_OVF_EN
        chk("drop_ovf_set", 32'(a_ovf), 32'h1);
`endif
        tick(); chk_a("drop_c4", 8'h02, 1'b1, 1'b0);
        tick(); chk_a("drop_c5", 8'h08, 1'b1, 1'b1);
        tick(); chk_a("drop_c6", 8'h08, 1'b1, 1'b1);
        tick(); chk_a("drop_c7", 8'h08, 1'b1, 1'b1);
        tick(); chk_a("drop_c8", 8'h08, 1'b1, 1'b1);
        tick(); chk_a("drop_end", 8'h00, 1'b0, 1'b1);
        chk("drop_end_busy", 32'(a_busy), 32'h0);
`ifdef DEC_OVF_EN
        chk("drop_ovf_sticky", 32'(a_ovf), 32'h1);
`endif

        // async reset mid-hold with a=5 showing
        a_vin = 1'b1; a_a = 3'd5;
        tick(); a_vin = 1'b0;
        chk_a("mid_shown", 8'h20, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_a("mid_rst", 8'h00, 1'b0, 1'b1);
        chk("mid_rst_busy", 32'(a_busy), 32'h0);
`ifdef DEC_OVF_EN
        chk("mid_rst_ovf", 32'(a_ovf), 32'h0);
`endif
        tick();
        chk_a("mid_rst_held", 8'h00, 1'b0, 1'b1);
        rst_n = 1'b1;

        // full throughput, HOLD 1
        b_vin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_a = 3'(i);
            tick();
            chk($sformatf("tput_out%0d", i), 32'(b_out), 32'(8'h01 << i));
            chk($sformatf("tput_vout%0d", i), 32'(b_vout), 32'h1);
            chk($sformatf("tput_rdy%0d", i), 32'(b_rdy), 32'h1);
        end
        b_vin = 1'b0;
        tick();
        chk("tput_end_out", 32'(b_out), 32'h00);
        chk("tput_end_vout", 32'(b_vout), 32'h0);

        // final-edge bypass, HOLD 3
        c_vin = 1'b1; c_a = 3'd0;
        tick(); c_vin = 1'b0;
        chk("byp_c1", 32'(c_out), 32'h01);
        tick(); chk("byp_c2", 32'(c_out), 32'h01);
        tick(); chk("byp_c3", 32'(c_out), 32'h01);
        c_vin = 1'b1; c_a = 3'd3;
        tick(); c_vin = 1'b0;
        chk("byp_c4", 32'(c_out), 32'h08);
        chk("byp_c4_vout", 32'(c_vout), 32'h1);
        chk("byp_c4_rdy", 32'(c_rdy), 32'h1);
        tick(); chk("byp_c5", 32'(c_out), 32'h08);
        chk("byp_c5_rdy", 32'(c_rdy), 32'h1);
        tick(); chk("byp_c6", 32'(c_out), 32'h08);
        tick(); chk("byp_end", 32'(c_out), 32'h00);
        chk("byp_end_vout", 32'(c_vout), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/one_hot_decoder.md
# one_hot_decoder

Registered 3-to-8 decoder with pulse hold, forming the receive end of the priority-encoder interface. It accepts a binary code `a` qualified by `vin`, and drives the matching one-hot vector on `out` with `vout` for a programmable number of cycles. A one-deep pending register absorbs one code that arrives during a hold. Downstream logic therefore sees each priority index as a clean, stretched one-hot strobe.

## Interface
- `N_SEL`, 3: code width; `OUT_W = 1 << N_SEL` (8 by default).
- `HOLD_CYCLES`, 4: cycles each decoded vector is presented; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `vin` input 1: code valid; sampled on a rising edge when `rdy`=1.
- `a` input N_SEL: binary code to decode.
- `rdy` output 1: accept indicator; equals NOT `pend_v`.
- `out` output OUT_W: one-hot decoded vector, registered.
- `vout` output 1: `out` is valid.
- `busy` output 1: a hold is in progress or a code is pending.
- `ovf` output 1: present only with `DEC_OVF_EN`; sticky dropped-code flag.

## Operation
- **Reset values:** state IDLE, `out`=0, `vout`=0, hold counter `cnt`=0, `pend_v`=0, `rdy`=1, `busy`=0, `ovf`=0.
- **State IDLE** (`vout`=0):
  - `vin`=1 loads `out` <= 1<<`a`, `vout` <= 1, `cnt` <= HOLD_CYCLES-1, and moves to HOLD.
  - `vin`=0 keeps `out`=0.
- **State HOLD** (`vout`=1, `out` stable), non-final edge (`cnt`≠0):
  - `cnt` decrements.
  - `vin`=1 with `pend_v`=0 captures `a` into `pend`, and `pend_v` <= 1.
- **State HOLD, final edge** (`cnt`=0):
  - If `pend_v`=1: load `pend` into `out`, reload `cnt`, clear `pend_v`, stay in HOLD. The vector changes with no gap.
  - Else if `vin`=1: load `a` directly into `out` (bypass), reload `cnt`, stay in HOLD.
  - Else: `out` <= 0, `vout` <= 0, go to IDLE.
- **Final edge with both `pend_v`=1 and `vin`=1:** `rdy`=0, so `vin` is not accepted. The code is dropped.
- **Drop rule:** `vin`=1 while `rdy`=0 is ignored. No state changes except `ovf`.
- `busy` = (state==HOLD) OR `pend_v`.
- `rdy` is a function of registered state only, with no combinational path from `vin`.
- **Codes:** all 2^N_SEL values are legal. Code 0 decodes to `out`[0]=1, not to an all-zero vector.

## Timing
- **Latency:** code accepted at edge k appears on `out`/`vout` after edge k, i.e. 1 cycle.
- **Hold length:** each vector is valid for exactly HOLD_CYCLES cycles.
- **HOLD_CYCLES=1:**
  - Every cycle is a final edge, so sustained one-code-per-cycle throughput occurs via the bypass.
  - The pending register is never used in this case.
- **Back-to-back:** consecutive accepted codes produce contiguous `vout` with no idle cycle between them.
- **Reset mid-hold:** `rst_n` low clears `out`, `vout`, `pend_v`, and `cnt` immediately, without waiting for a clock. The first accept is at the first rising edge after `rst_n` rises.

## Configuration
- **`DEC_OVF_EN` defined:**
  - Adds port `ovf`.
  - `ovf` is set on any edge where `vin`=1 and `rdy`=0.
  - It stays set until `rst_n` is asserted.
- **`DEC_OVF_EN` undefined:** port `ovf` and its logic are absent. Dropped codes are silently discarded.

## Test plan
- **Reset:** assert `rst_n`=0 mid-hold with `a`=5 displayed -> `out`=0x00, `vout`=0, `rdy`=1, `busy`=0 immediately.
- **Single code:** HOLD_CYCLES=4, one-cycle `vin` with `a`=6 -> `out`=0x40 and `vout`=1 for exactly 4 cycles starting 1 cycle later, then `out`=0x00, `vout`=0.
- **Pending:** HOLD_CYCLES=4, `a`=2 then `a`=7 two cycles later -> `out`=0x04 for 4 cycles, then `out`=0x80 for 4 cycles. `vout` stays continuous for 8 cycles. `rdy` is low from the capture edge until the load edge.
- **Drop:** HOLD_CYCLES=4, send `a`=1, `a`=3, `a`=4 on consecutive cycles -> `out` shows 0x02 then 0x08. Code 4 is never shown. With `DEC_OVF_EN`, `ovf`=1 from that edge until reset.
- **Full throughput:** HOLD_CYCLES=1, stream `a`=0..7 with `vin` held high -> `out`=0x01,0x02,…,0x80 on consecutive cycles. `vout` stays high and `rdy` stays 1 throughout.
- **Final-edge bypass:** HOLD_CYCLES=3, send `a`=0, then `a`=3 exactly on its final hold edge -> `out`=0x01 for 3 cycles, then 0x08 for 3 cycles. `pend_v` never sets.
